// File: rtl/shufflev_instr_mem_responder.sv
// Instruction RAM responder for the fetch req/gnt/rvalid bus.
// Optional SHUFFLEV_IMEM_STALL_EN adds LFSR-driven grant stalls.
//
// Ports:
//   clk_i, rst_ni        clock, async active-low reset
//   instr_req_i/gnt_o    fetch request / same-cycle grant
//   instr_addr_i         fetch byte address (bits [1:0] ignored)
//   instr_rvalid_o       one-cycle response pulse per grant
//   instr_rdata_o/err_o  response data / error (0 when idle)
//   load_we_i/addr/wdata backdoor program load
//   outstanding_o        granted-but-unanswered count
module shufflev_instr_mem_responder #(
  parameter int unsigned MemWords       = 1024,
  parameter logic [31:0] BaseAddr       = 32'h0010_0000,
  parameter int unsigned Latency        = 2,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        instr_req_i,
  output logic        instr_gnt_o,
  input  logic [31:0] instr_addr_i,
  output logic        instr_rvalid_o,
  output logic [31:0] instr_rdata_o,
  output logic        instr_err_o,
  input  logic        load_we_i,
  input  logic [31:0] load_addr_i,
  input  logic [31:0] load_wdata_i,
  output logic [3:0]  outstanding_o
);

  localparam int unsigned IW =
    (MemWords > 1) ? $clog2(MemWords) : 1;
  localparam int unsigned PW =
    (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam logic [3:0] LatRem = 4'(Latency - 1);
  localparam logic [3:0] MaxCnt = 4'(MaxOutstanding);
  localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);

  logic [31:0] mem_q [MemWords];

  logic [31:0] off_w;
  logic        in_rng_w;
  logic [IW-1:0] idx_w;
  logic [31:0] rd_w;

  logic [31:0] ld_off_w;
  logic        ld_rng_w;
  logic [IW-1:0] ld_idx_w;

  logic [31:0] qdata_q [MaxOutstanding];
  logic        qerr_q  [MaxOutstanding];
  logic [3:0]  qrem_q  [MaxOutstanding];

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [3:0]    qcnt_q, qcnt_d;
  logic [3:0]    cnt_q, cnt_d;

  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic gnt_w, stall_w, push_w, pop_w;

  assign off_w    = instr_addr_i - BaseAddr;
  assign in_rng_w = (instr_addr_i >= BaseAddr) &&
                    ((off_w >> 2) < MemWords);
  assign idx_w    = off_w[IW+1:2];
  assign rd_w     = in_rng_w ? mem_q[idx_w] : '0;

  assign ld_off_w = load_addr_i - BaseAddr;
  assign ld_rng_w = (load_addr_i >= BaseAddr) &&
                    ((ld_off_w >> 2) < MemWords);
  assign ld_idx_w = ld_off_w[IW+1:2];

`ifdef SHUFFLEV_IMEM_STALL_EN
  logic [7:0] lfsr_q;
  logic       fb_w;

  // Fibonacci taps 8,6,5,4
  assign fb_w = lfsr_q[7] ^ lfsr_q[5] ^
                lfsr_q[4] ^ lfsr_q[3];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) lfsr_q <= 8'hA5;
    else         lfsr_q <= {lfsr_q[6:0], fb_w};
  end

  assign stall_w = (lfsr_q[1:0] == 2'b00);
`else
  assign stall_w = 1'b0;
`endif

  // A slot whose response is on the bus now may be reused.
  assign gnt_w = rst_ni && instr_req_i && !stall_w &&
                 ((cnt_q < MaxCnt) || rvalid_q);

  always_comb begin
    push_w   = 1'b0;
    pop_w    = 1'b0;
    rvalid_d = 1'b0;
    rdata_d  = '0;
    err_d    = 1'b0;
    if (Latency == 1) begin
      // Response registered straight from the grant-cycle read.
      rvalid_d = gnt_w;
      rdata_d  = gnt_w ? rd_w : '0;
      err_d    = gnt_w && !in_rng_w;
    end else begin
      push_w   = gnt_w;
      pop_w    = (qcnt_q != '0) && (qrem_q[head_q] == 4'd1);
      rvalid_d = pop_w;
      rdata_d  = pop_w ? qdata_q[head_q] : '0;
      err_d    = pop_w && qerr_q[head_q];
    end
  end

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    if (pop_w)
      head_d = (head_q == LastPtr) ? '0 : head_q + 1'b1;
    if (push_w)
      tail_d = (tail_q == LastPtr) ? '0 : tail_q + 1'b1;
    qcnt_d = qcnt_q + {3'b0, push_w} - {3'b0, pop_w};
    cnt_d  = cnt_q + {3'b0, gnt_w} - {3'b0, rvalid_q};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head_q   <= '0;
      tail_q   <= '0;
      qcnt_q   <= '0;
      cnt_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      head_q   <= head_d;
      tail_q   <= tail_d;
      qcnt_q   <= qcnt_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
    end
  end

  // Entry timers count down to 1, at which edge the head pops.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < int'(MaxOutstanding); i++) begin
      if (qrem_q[i] != 4'd0) qrem_q[i] <= qrem_q[i] - 4'd1;
    end
    if (push_w) begin
      qdata_q[tail_q] <= rd_w;
      qerr_q[tail_q]  <= !in_rng_w;
      qrem_q[tail_q]  <= LatRem;
    end
  end

  // Grant-cycle read sees pre-write contents on a collision.
  always_ff @(posedge clk_i) begin
    if (load_we_i && ld_rng_w) mem_q[ld_idx_w] <= load_wdata_i;
  end

  assign instr_gnt_o    = gnt_w;
  assign instr_rvalid_o = rvalid_q;
  assign instr_rdata_o  = rdata_q;
  assign instr_err_o    = err_q;
  assign outstanding_o  = cnt_q;

endmodule
